// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass, hardwired x0 and a post-reset clear sequencer
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     init_busy,
  output logic                     wr_drop
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_nx;
  // the clear ends on the edge where the counter has reached the last entry
  always_comb begin
    state_nx  = (state == INIT && &cnt) ? READY : state;
    init_busy = state == INIT;
    wr_ok     = state == READY && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  end
  // state register, reset drops the file back into the clear sequence
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INIT;
    else state <= state_nx;
  // clear address counter, walks every entry once while clearing
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  // storage: zeroed by the sequencer, then written from the writeback port
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt] <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  // flag writes that arrive while the clear sequence owns the array
  always_ff @(posedge clk or posedge rst)
    if (rst) wr_drop <= 1'b0;
    else wr_drop <= state == INIT && wr_en;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_nx[i*DATA_W +: DATA_W] = (ZERO_REG != 0 && a == '0) ? '0 :
                                       (BYPASS != 0 && wr_ok && wr_addr == a) ? wr_data : mem[a];
  end
  // registered read ports; data holds when a port is idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else if (state == READY) begin
      rd_valid <= rd_en;
      for (int i = 0; i < NUM_RD; i++)
        if (rd_en[i]) rd_data[i*DATA_W +: DATA_W] <= rd_nx[i*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp with bypass on and off
module tb_regfile_mp;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] rd_en;
  logic [9:0] rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0] rd_valid, rd_valid_nb;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic init_busy, wr_drop, init_busy_nb, wr_drop_nb;
  int errors = 0, checks = 0;
  logic [31:0] ref_mem [32];
  logic [63:0] hold_b, hold_nb;
  typedef struct {logic [1:0] re; logic [63:0] d; logic [63:0] dnb;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  regfile_mp u_dut (.clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(init_busy), .wr_drop(wr_drop));
  regfile_mp #(.BYPASS(0)) u_nb (.clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_valid(rd_valid_nb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .init_busy(init_busy_nb), .wr_drop(wr_drop_nb));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    hold_b = '0;
    hold_nb = '0;
    q.delete();
  endtask
  task automatic init_wait(input int drop_at);
    rd_en = 2'b11;
    rd_addr = {5'd1, 5'd2};
    wr_en = 1'b0;
    wr_addr = 5'd3;
    wr_data = 32'hAAAA5555;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("init busy e%0d", k), {63'b0, init_busy}, {63'b0, k < 32});
      chk($sformatf("init busy_nb e%0d", k), {63'b0, init_busy_nb}, {63'b0, k < 32});
      chk($sformatf("init drop e%0d", k), {63'b0, wr_drop}, {63'b0, k == drop_at + 1});
      chk($sformatf("init valid e%0d", k), {62'b0, rd_valid}, 64'h0);
      chk($sformatf("init data e%0d", k), rd_data, 64'h0);
      wr_en = (k == drop_at);
    end
    wr_en = 1'b0;
  endtask
  task automatic step(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input string tag);
    exp_t e;
    logic [4:0] a [2];
    a[0] = a0;
    a[1] = a1;
    rd_en = re;
    rd_addr = {a1, a0};
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    e.re = re;
    e.d = hold_b;
    e.dnb = hold_nb;
    for (int i = 0; i < 2; i++)
      if (re[i]) begin
        e.d[i*32 +: 32] = (a[i] == 5'd0) ? 32'h0 : (we && wa == a[i]) ? wd : ref_mem[a[i]];
        e.dnb[i*32 +: 32] = (a[i] == 5'd0) ? 32'h0 : ref_mem[a[i]];
      end
    hold_b = e.d;
    hold_nb = e.dnb;
    q.push_back(e);
    if (we && wa != 5'd0) ref_mem[wa] = wd;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, " data"}, rd_data, e.d);
    chk({tag, " data_nb"}, rd_data_nb, e.dnb);
    chk({tag, " valid"}, {62'b0, rd_valid}, {62'b0, e.re});
    chk({tag, " valid_nb"}, {62'b0, rd_valid_nb}, {62'b0, e.re});
    chk({tag, " drop"}, {62'b0, wr_drop, wr_drop_nb}, 64'h0);
    chk({tag, " busy"}, {63'b0, init_busy}, 64'h0);
  endtask
  initial begin
    rd_en = '0;
    rd_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset busy", {62'b0, init_busy, init_busy_nb}, 64'h3);
    chk("reset valid", {60'b0, rd_valid, rd_valid_nb}, 64'h0);
    chk("reset data", rd_data | rd_data_nb, 64'h0);
    chk("reset drop", {62'b0, wr_drop, wr_drop_nb}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    init_wait(9);
    for (int a = 0; a < 32; a++) step(2'b11, a[4:0], 5'(31 - a), 1'b0, 5'd0, 32'h0, "sweep");
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, "wr5");
    step(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, "rd5");
    step(2'b00, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, "hold5");
    step(2'b10, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0, "rd5 p1");
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111, "wr7");
    step(2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22222222, "bypass7");
    step(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, "rd7 after");
    step(2'b11, 5'd7, 5'd5, 1'b1, 5'd5, 32'h0BADF00D, "bypass p1 only");
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, "wr x0");
    step(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, "x0 bypass");
    step(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, "x0 read");
    step(2'b11, 5'd3, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D, "rd3 wr31");
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h12345678, "wr9");
    step(2'b11, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0, "rd9");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst data", rd_data | rd_data_nb, 64'h0);
    chk("midrst valid", {60'b0, rd_valid, rd_valid_nb}, 64'h0);
    chk("midrst busy", {62'b0, init_busy, init_busy_nb}, 64'h3);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    init_wait(-1);
    step(2'b11, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0, "rd9 after rst");
    step(2'b01, 5'd31, 5'd0, 1'b0, 5'd0, 32'h0, "rd31 after rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
